two_ch_splitter: RTL

TWO_CH_SPLITTER -- requirements
Module: two_ch_splitter

---
 rtl/krd_frame_pkg.sv | 53 +++++
 rtl/splitter_out_reg.sv | 37 +++
 rtl/two_ch_splitter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/krd_frame_pkg.sv
// Shared frame-format definitions for the two-channel splitter.
// Holds the header/footer marker values, the synthetic lost-footer word,
// header field bit positions, the splitter FSM state type and small
// word-classification helpers.
package krd_frame_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned CH_ID_W = 4;

  // Marker values
  localparam logic [7:0]        HDR_ID      = 8'hFF;
  localparam logic [7:0]        FTR_ID      = 8'h0F;
  localparam logic [3:0]        FTR_NIB     = 4'hF;
  localparam logic [WORD_W-1:0] LOST_FOOTER = 64'h0000_0000_0000_0000;

  // Field bit positions
  localparam int unsigned HDR_ID_MSB   = 63;
  localparam int unsigned HDR_ID_LSB   = 56;
  localparam int unsigned FTR_NIB_MSB  = 63;
  localparam int unsigned FTR_NIB_LSB  = 60;
  localparam int unsigned FTR_ID_MSB   = 7;
  localparam int unsigned FTR_ID_LSB   = 0;
  localparam int unsigned CH_ID_MSB    = 55;
  localparam int unsigned CH_ID_LSB    = 52;
  localparam int unsigned TS_HI_MSB    = 51;
  localparam int unsigned TS_HI_LSB    = 36;
  localparam int unsigned TS_LO_MSB    = 35;
  localparam int unsigned TS_LO_LSB    = 20;
  localparam int unsigned BASELINE_MSB = 19;
  localparam int unsigned BASELINE_LSB = 10;
  localparam int unsigned THRESH_MSB   = 9;
  localparam int unsigned THRESH_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ROUTE      = 2'd1,
    INS_FOOTER = 2'd2,
    DROP       = 2'd3
  } state_t;

  function automatic logic is_header(input logic [WORD_W-1:0] w);
    return w[HDR_ID_MSB:HDR_ID_LSB] == HDR_ID;
  endfunction

  function automatic logic is_footer(input logic [WORD_W-1:0] w);
    return (w[FTR_NIB_MSB:FTR_NIB_LSB] == FTR_NIB) && (w[FTR_ID_MSB:FTR_ID_LSB] == FTR_ID);
  endfunction

  function automatic logic [CH_ID_W-1:0] chan_id(input logic [WORD_W-1:0] w);
    return w[CH_ID_MSB:CH_ID_LSB];
  endfunction

endpackage

// File: rtl/splitter_out_reg.sv
// Single-entry valid/ready output register for one splitter channel.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - capture word this cycle (only asserted when open_c=1)
//   word        - word to capture
//   take        - downstream ready
//   q, valid    - registered output word and its valid flag
//   open_c      - combinational: a new word may be loaded this cycle
module splitter_out_reg #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         take,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         open_c
);

  // Empty, or the held word leaves this cycle
  assign open_c = !valid || take;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= word;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/two_ch_splitter.sv
// Two-channel frame splitter: routes header/data/footer frames from one
// stream to CH0 or CH1 by the header channel ID, discards orphan and
// bad-channel words, closes frames whose footer went missing with a
// synthetic footer, and keeps saturating statistics counters.
// Ports:
//   CLK, RESET                          - clock, synchronous active-high reset
//   DIN, iVALID, oREADY                 - input stream (oREADY is combinational)
//   CHx_DOUT, CHx_oVALID, CHx_iREADY    - per-channel registered outputs
//   FRAME_CNT, HEADER_LOST_CNT,
//   FOOTER_LOST_CNT, BAD_CH_CNT         - saturating counters
// Build option: SPLITTER_ERR_CNT_EN enables the three error counters;
// without it they read as zero.
module two_ch_splitter
  import krd_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  iVALID,
  output logic                  oREADY,
  output logic [DATA_WIDTH-1:0] CH0_DOUT,
  output logic                  CH0_oVALID,
  input  logic                  CH0_iREADY,
  output logic [DATA_WIDTH-1:0] CH1_DOUT,
  output logic                  CH1_oVALID,
  input  logic                  CH1_iREADY,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic [CNT_WIDTH-1:0]  HEADER_LOST_CNT,
  output logic [CNT_WIDTH-1:0]  FOOTER_LOST_CNT,
  output logic [CNT_WIDTH-1:0]  BAD_CH_CNT
);

  state_t               state_q, state_d;
  logic                 ch_q, ch_d;
  logic                 is_hdr, is_ftr, id_ok;
  logic [CH_ID_W-1:0]   din_ch;
  logic [1:0]           can_load;
  logic [1:0]           load;
  logic                 ready_c, fwd_c, tgt_c, ins_c, frame_inc_c, take_c;
  logic [DATA_WIDTH-1:0] word_c;

  // Input word classification; header wins over the footer pattern
  assign is_hdr = is_header(DIN);
  assign is_ftr = is_footer(DIN);
  assign din_ch = chan_id(DIN);
  assign id_ok  = (din_ch == CH_ID_W'(0)) || (din_ch == CH_ID_W'(1));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ch_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Next state, ready and routing decisions
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    ready_c     = 1'b0;
    fwd_c       = 1'b0;
    tgt_c       = ch_q;
    ins_c       = 1'b0;
    frame_inc_c = 1'b0;
    case (state_q)
      IDLE, DROP: begin
        if (is_hdr && id_ok) begin
          // Ready looks only at the channel this header targets
          tgt_c   = din_ch[0];
          fwd_c   = 1'b1;
          ready_c = can_load[din_ch[0]];
          if (iVALID && ready_c) begin
            state_d = ROUTE;
            ch_d    = din_ch[0];
          end
        end else begin
          ready_c = 1'b1;
          if (iVALID && is_hdr) begin
            state_d = DROP;
          end else if (iVALID && is_ftr) begin
            state_d = IDLE;
          end
        end
      end
      ROUTE: begin
        if (is_hdr) begin
          // Header inside an open frame: hold it off and close the frame first
          if (iVALID) begin
            state_d = INS_FOOTER;
          end
        end else begin
          fwd_c   = 1'b1;
          ready_c = can_load[ch_q];
          if (iVALID && ready_c && is_ftr) begin
            frame_inc_c = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      INS_FOOTER: begin
        ins_c = can_load[ch_q];
        if (ins_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign oREADY = ready_c && !RESET;
  assign take_c = iVALID && oREADY;
  assign word_c = ins_c ? DATA_WIDTH'(LOST_FOOTER) : DIN;
  assign load[0] = (take_c && fwd_c && !tgt_c) || (ins_c && !ch_q);
  assign load[1] = (take_c && fwd_c &&  tgt_c) || (ins_c &&  ch_q);

  splitter_out_reg #(.W(DATA_WIDTH)) u_ch0_reg (
    .clk    (CLK),
    .reset  (RESET),
    .load   (load[0]),
    .word   (word_c),
    .take   (CH0_iREADY),
    .q      (CH0_DOUT),
    .valid  (CH0_oVALID),
    .open_c (can_load[0])
  );

  splitter_out_reg #(.W(DATA_WIDTH)) u_ch1_reg (
    .clk    (CLK),
    .reset  (RESET),
    .load   (load[1]),
    .word   (word_c),
    .take   (CH1_iREADY),
    .q      (CH1_DOUT),
    .valid  (CH1_oVALID),
    .open_c (can_load[1])
  );

  // Completed-frame counter, saturating
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FRAME_CNT <= '0;
    end else if (frame_inc_c && (FRAME_CNT != '1)) begin
      FRAME_CNT <= FRAME_CNT + CNT_WIDTH'(1);
    end
  end

`ifdef SPLITTER_ERR_CNT_EN
  logic orphan_q;
  logic orphan_c, ftr_lost_c, bad_ch_c;

  // Error events; IDLE/DROP always accept non-forwarded words
  assign orphan_c   = (state_q == IDLE) && iVALID && !is_hdr;
  assign ftr_lost_c = (state_q == ROUTE) && iVALID && is_hdr;
  assign bad_ch_c   = ((state_q == IDLE) || (state_q == DROP)) && iVALID && is_hdr && !id_ok;

  // Error counters; orphan_q marks an ongoing orphan run so it counts once
  always_ff @(posedge CLK) begin
    if (RESET) begin
      orphan_q        <= 1'b0;
      HEADER_LOST_CNT <= '0;
      FOOTER_LOST_CNT <= '0;
      BAD_CH_CNT      <= '0;
    end else begin
      orphan_q <= (state_q == IDLE) && (orphan_c || (orphan_q && !(iVALID && is_hdr)));
      if (orphan_c && !orphan_q && (HEADER_LOST_CNT != '1)) begin
        HEADER_LOST_CNT <= HEADER_LOST_CNT + CNT_WIDTH'(1);
      end
      if (ftr_lost_c && (FOOTER_LOST_CNT != '1)) begin
        FOOTER_LOST_CNT <= FOOTER_LOST_CNT + CNT_WIDTH'(1);
      end
      if (bad_ch_c && (BAD_CH_CNT != '1)) begin
        BAD_CH_CNT <= BAD_CH_CNT + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign HEADER_LOST_CNT = '0;
  assign FOOTER_LOST_CNT = '0;
  assign BAD_CH_CNT      = '0;
`endif

endmodule
